// File: rtl/spi_tx_buffer.sv
// SPI-mode card-side response transmitter. Response bytes are queued in a small FIFO and
// serialised MSB first on DO. The idle FILL pattern is sent whenever no byte is queued.
module spi_tx_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  FILL  = 8'hFF
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic                     CS,
  input  logic                     IsInitialized,
  input  logic                     Align,
  input  logic [7:0]               Data,
  input  logic                     Load,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     DO,
  output logic                     Sent
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          sent_q, sent_d;
  logic          from_fifo_q, from_fifo_d;
  logic          push, pop, boundary, full, empty;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign boundary = (cnt_q == 3'd7) || Align;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    sent_d      = sent_q;
    from_fifo_d = from_fifo_q;
    push        = 1'b0;
    pop         = 1'b0;
    if (!IsInitialized) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      sr_d        = FILL;
      cnt_d       = '0;
      sent_d      = 1'b0;
      from_fifo_d = 1'b0;
    end else begin
      // Full is taken before any same-edge pop, so a Load while full is dropped.
      push = Load && !full;
      if (CS) begin
        cnt_d       = '0;
        sr_d        = FILL;
        from_fifo_d = 1'b0;
        sent_d      = 1'b0;
      end else if (boundary) begin
        if (!empty) begin
          sr_d        = mem[rptr_q];
          pop         = 1'b1;
          from_fifo_d = 1'b1;
        end else begin
          sr_d        = FILL;
          from_fifo_d = 1'b0;
        end
        cnt_d  = '0;
        sent_d = from_fifo_q;
      end else begin
        sr_d   = {sr_q[6:0], 1'b1};
        cnt_d  = cnt_q + 3'd1;
        sent_d = 1'b0;
      end
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      sr_q        <= FILL;
      cnt_q       <= '0;
      sent_q      <= 1'b0;
      from_fifo_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      from_fifo_q <= from_fifo_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr_q] <= Data;
  end

  assign Full  = full;
  assign Empty = empty;
  assign Level = level_q;
  assign DO    = sr_q[7];
  assign Sent  = sent_q;

endmodule

// File: tb/tb_spi_tx_buffer.sv
// Self-checking bench for spi_tx_buffer: directed vector table, corner-case sequences and
// randomised traffic checked against a queue-based model of the transmitted bit stream.
module tb_spi_tx_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  FILL  = 8'hFF;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          reset_n;
  logic          CS;
  logic          IsInitialized;
  logic          Align;
  logic [7:0]    Data;
  logic          Load;
  logic          Full;
  logic          Empty;
  logic [LW-1:0] Level;
  logic          DO;
  logic          Sent;

  int n_checks = 0;
  int n_fail   = 0;

  spi_tx_buffer #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .CS           (CS),
    .IsInitialized(IsInitialized),
    .Align        (Align),
    .Data         (Data),
    .Load         (Load),
    .Full         (Full),
    .Empty        (Empty),
    .Level        (Level),
    .DO           (DO),
    .Sent         (Sent)
  );

  always #5 CLK = ~CLK;

  // Model: the byte currently on the wire, the bit position within it, and the byte queue.
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  int         m_pos;
  logic       m_ff;
  logic       m_sent;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_byte = FILL;
    m_pos  = 0;
    m_ff   = 1'b0;
    m_sent = 1'b0;
  endtask

  task automatic model_step();
    bit full_pre;
    if (!IsInitialized) begin
      model_reset();
      return;
    end
    full_pre = (m_q.size() == DEPTH);
    if (CS) begin
      m_byte = FILL;
      m_pos  = 0;
      m_ff   = 1'b0;
      m_sent = 1'b0;
    end else if (m_pos == 7 || Align) begin
      m_sent = m_ff;
      if (m_q.size() > 0) begin
        m_byte = m_q.pop_front();
        m_ff   = 1'b1;
      end else begin
        m_byte = FILL;
        m_ff   = 1'b0;
      end
      m_pos = 0;
    end else begin
      m_pos++;
      m_sent = 1'b0;
    end
    if (Load && !full_pre) m_q.push_back(Data);
  endtask

  task automatic compare_model();
    logic [7:0] b;
    b = m_byte;
    check("model_do",    DO,    b[7-m_pos]);
    check("model_sent",  Sent,  m_sent);
    check("model_level", Level, m_q.size());
    check("model_empty", Empty, m_q.size() == 0);
    check("model_full",  Full,  m_q.size() == DEPTH);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic clear_block();
    Load = 1'b0; Align = 1'b0; CS = 1'b1;
    IsInitialized = 1'b0;
    tick();
    IsInitialized = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    Load = 1'b1; Data = b;
    tick();
    Load = 1'b0;
  endtask

  typedef struct {
    logic       cs;
    logic       load;
    logic [7:0] data;
    logic       exp_do;
    logic       exp_sent;
    int         exp_level;
  } vec_t;

  vec_t        vecs[26];
  logic [31:0] stream;

  initial begin
    // Expected wire stream: FILL, 0x01, 0xA5, then FILL again.
    stream = {FILL, 8'h01, 8'hA5, FILL};
    vecs[0] = '{cs: 1'b1, load: 1'b1, data: 8'h01, exp_do: 1'b1, exp_sent: 1'b0, exp_level: 1};
    vecs[1] = '{cs: 1'b1, load: 1'b1, data: 8'hA5, exp_do: 1'b1, exp_sent: 1'b0, exp_level: 2};
    for (int k = 1; k <= 24; k++) begin
      vecs[k+1].cs        = 1'b0;
      vecs[k+1].load      = 1'b0;
      vecs[k+1].data      = 8'h00;
      vecs[k+1].exp_do    = stream[31-k];
      vecs[k+1].exp_sent  = (k == 16) || (k == 24);
      vecs[k+1].exp_level = (k < 8) ? 2 : (k < 16) ? 1 : 0;
    end

    reset_n = 1'b1; CS = 1'b1; IsInitialized = 1'b1; Align = 1'b0; Load = 1'b0; Data = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_do",    DO,    1);
    check("rst_sent",  Sent,  0);
    check("rst_level", Level, 0);
    check("rst_empty", Empty, 1);
    check("rst_full",  Full,  0);
    #9 reset_n = 1'b1;

    // Idle line with an empty FIFO.
    CS = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("idle_do", DO, 1);
      check("idle_sent", Sent, 0);
      check("idle_empty", Empty, 1);
    end

    // Two bytes primed while deselected, then 24 clocks.
    for (int i = 0; i < 26; i++) begin
      CS = vecs[i].cs; Load = vecs[i].load; Data = vecs[i].data;
      tick();
      check("vec_do",    DO,    vecs[i].exp_do);
      check("vec_sent",  Sent,  vecs[i].exp_sent);
      check("vec_level", Level, vecs[i].exp_level);
    end
    Load = 1'b0;
    check("vec_empty_end", Empty, 1);

    // Overfill: fifth byte dropped, survivors leave in push order.
    clear_block();
    for (int i = 0; i < 5; i++) begin
      push_byte(8'(8'h11 * (i + 1)));
      check("fill_full", Full, i >= 3);
    end
    check("fill_level", Level, 4);
    CS = 1'b0;
    for (int i = 0; i < 48; i++) tick();
    check("fill_empty_end", Empty, 1);

    // Align forces an early boundary.
    clear_block();
    push_byte(8'h00);
    CS = 1'b0;
    tick(); tick();
    Align = 1'b1;
    tick();
    Align = 1'b0;
    check("align_do_first", DO, 0);
    for (int i = 4; i <= 10; i++) begin
      tick();
      check("align_do", DO, 0);
      check("align_sent_early", Sent, 0);
    end
    tick();
    check("align_sent", Sent, 1);
    check("align_do_fill", DO, 1);

    // CS rises mid-byte: partial byte discarded, no Sent, fresh FILL byte afterwards.
    clear_block();
    push_byte(8'h3C);
    push_byte(8'h81);
    CS = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    CS = 1'b1;
    tick();
    check("csmid_do", DO, 1);
    check("csmid_sent", Sent, 0);
    check("csmid_level", Level, 1);
    CS = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("csmid_sent_fill", Sent, 0);
      if (i < 8) check("csmid_fill_do", DO, 1);
    end
    check("csmid_level_pop", Level, 0);
    tick();
    check("csmid_0x81_bit6", DO, 0);
    for (int i = 0; i < 7; i++) tick();
    check("csmid_sent_81", Sent, 1);

    // Asynchronous reset mid-byte with bytes still queued.
    clear_block();
    for (int i = 0; i < 4; i++) push_byte(8'h00);
    CS = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("arst_pre_do", DO, 0);
    check("arst_pre_level", Level, 3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_do", DO, 1);
    check("arst_level", Level, 0);
    check("arst_empty", Empty, 1);
    check("arst_sent", Sent, 0);
    #3 reset_n = 1'b1;

    // Random traffic against the model.
    CS = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) CS = ~CS;
      Load          = ($urandom_range(0, 2) == 0);
      Data          = 8'($urandom);
      Align         = ($urandom_range(0, 19) == 0);
      IsInitialized = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_tx_buffer.md
Name: spi_tx_buffer

Overview:
- SPI-mode card-side transmitter: serialises response bytes onto DO, MSB first, for the host to sample.
- Counterpart of the command receive buffer that deserialises DI. Clocked by the same SPI clock; framed by the same CS.
- Card logic pushes response bytes into a small FIFO. While no response byte is queued, the block emits the idle FILL pattern (0xFF) so the host sees an idle line.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of 2, minimum 2.
- FILL, 8'hFF, byte shifted out when the FIFO is empty or CS is high.

Ports:
- CLK  input  1  SPI serial clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- CS  input  1  chip select, active-low: high means deselected.
- IsInitialized  input  1  card-init complete; low freezes and clears the block.
- Align  input  1  forces the current edge to be a byte boundary; qualified by CS low.
- Data  input  8  response byte to enqueue.
- Load  input  1  enqueue strobe for Data.
- Full  output  1  FIFO holds DEPTH bytes.
- Empty  output  1  FIFO holds 0 bytes.
- Level  output  $clog2(DEPTH)+1  FIFO occupancy.
- DO  output  1  serial data out (MISO); always equal to shift register bit 7.
- Sent  output  1  one-cycle pulse: a FIFO-sourced byte finished transmission.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Pointers 0, Level 0, Empty 1, Full 0.
  - Shift register SR = FILL, so DO = 1.
  - Bit counter cnt = 0, Sent 0, from_fifo flag 0.
- IsInitialized low (reset_n high): each posedge gives the same state as reset. FIFO cleared; Load ignored.
- Enqueue (IsInitialized high): Load && !Full pushes Data at the tail.
  - Full is sampled before any same-edge pop, so Load while Full drops Data with no state change.
  - Enqueue is independent of CS, so a response can be primed while deselected.
- CS high:
  - cnt <= 0; SR <= FILL; from_fifo <= 0; Sent <= 0.
  - FIFO contents retained.
- CS low, each posedge, with boundary = (cnt == 7) || Align:
  - If boundary and FIFO not empty: SR <= head, pop, from_fifo <= 1.
  - If boundary and FIFO empty: SR <= FILL, from_fifo <= 0.
  - On any boundary: cnt <= 0, and Sent <= from_fifo (the old value).
  - If not boundary: SR <= {SR[6:0],1'b1}; cnt <= cnt+1; Sent <= 0.
- Latency:
  - After CS falls, the first 8 clocks always carry FILL; this satisfies the minimum 1-byte response gap.
  - A byte queued before a boundary edge appears on DO in the cycle after that edge.
  - Its MSB is on DO for the first edge, bit 0 for the eighth.
- Simultaneous Load and pop:
  - FIFO not empty: pop head, push tail; Level unchanged.
  - FIFO empty: pop sees empty, so FILL is loaded and Data is enqueued; no bypass.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; Level is the occupancy counter.
- CS rising mid-byte: partially shifted byte is discarded (not resent) and Sent is not pulsed.
- Align at cnt == 7 behaves identically to a normal boundary.
- reset_n asserted mid-byte: immediate return to reset state; DO = 1 asynchronously.

Test Plan:
- Reset, CS low, 16 clocks with FIFO empty -> DO = 1 on every clock; Sent never asserts; Empty = 1.
- With CS high, Load 0x01 then 0xA5; drop CS; 24 clocks -> bits 1-8 all 1; bits 9-16 0,0,0,0,0,0,0,1; bits 17-24 1,0,1,0,0,1,0,1; Sent pulses after clock 16 and after clock 24; Empty = 1 at end.
- Load 5 bytes with DEPTH = 4 and no shifting -> Full = 1 after 4 pushes; 5th byte dropped; Level = 4; later bytes shift out in push order.
- CS low; raise Align at clock 3; 0x00 queued -> DO follows 0x00 starting the cycle after clock 3; a Sent pulse follows 8 clocks later.
- CS raised after 4 bits of 0x3C -> DO = 1 immediately; no Sent pulse; next queued byte starts after a fresh FILL byte when CS falls again.
- reset_n pulsed low mid-byte with 3 bytes queued -> DO = 1, Level = 0, Empty = 1 without any clock edge.
